// File: rtl/vec_loader.sv
// Serial-to-parallel vector loader: collects num_inputs elements plus a config word,
// then holds the assembled vector on w_data with wen high until the register file acks.
module vec_loader #(
   parameter int width      = 16,
   parameter int num_inputs = 8,
   parameter int cnt_width  = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               flush,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [width-1:0]                   in_data,
   output logic                               wen,
   output logic [num_inputs:0][width-1:0]     w_data,
   input  logic                               wr_ack,
   output logic                               busy,
   output logic                               done,
   output logic [cnt_width-1:0]               vec_count
);

   localparam int IDX_W = $clog2(num_inputs + 1);
   localparam logic [IDX_W-1:0]     IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]     IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(num_inputs);
   localparam logic [cnt_width-1:0] CNT_ONE  = {{(cnt_width-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      COLLECT  = 2'd0,
      WRITE    = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   state_t                          state_r, state_s;
   logic [IDX_W-1:0]                idx_r, idx_s;
   logic                            beat_s;
   logic                            ack_s;
   logic                            wen_r;
   logic                            done_r;
   logic [cnt_width-1:0]            vec_count_r;
   logic [num_inputs:0][width-1:0]  w_data_r;

   // Next-state and slot-index decode; flush only acts while collecting
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      beat_s  = 1'b0;
      ack_s   = 1'b0;
      case (state_r)
         COLLECT: begin
            if (flush) begin
               idx_s = IDX_ZERO;
            end else if (in_valid) begin
               beat_s = 1'b1;
               if (idx_r == IDX_LAST) begin
                  idx_s   = IDX_ZERO;
                  state_s = WRITE;
               end else begin
                  idx_s = idx_r + IDX_ONE;
               end
            end else begin
               idx_s = idx_r;
            end
         end
         WRITE: begin
            state_s = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (wr_ack) begin
               ack_s   = 1'b1;
               state_s = COLLECT;
            end else begin
               state_s = WAIT_ACK;
            end
         end
         default: begin
            state_s = COLLECT;
            idx_s   = IDX_ZERO;
         end
      endcase
   end

   // State, index and registered handshake outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= COLLECT;
         idx_r       <= IDX_ZERO;
         wen_r       <= 1'b0;
         done_r      <= 1'b0;
         vec_count_r <= {cnt_width{1'b0}};
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         // wen follows the next state so it rises right after the last beat
         wen_r   <= (state_s == WRITE) || (state_s == WAIT_ACK);
         done_r  <= ack_s;
         if (ack_s) begin
            vec_count_r <= vec_count_r + CNT_ONE;
         end
      end
   end

   // Slot storage: only the addressed slot is written; contents persist across vectors
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_data_r <= {((num_inputs + 1) * width){1'b0}};
      end else begin
         for (int i = 0; i <= num_inputs; i++) begin
            if (beat_s && (idx_r == IDX_W'(i))) begin
               w_data_r[i] <= in_data;
            end
         end
      end
   end

   assign in_ready  = (state_r == COLLECT);
   assign busy      = (state_r != COLLECT) || (idx_r != IDX_ZERO);
   assign wen       = wen_r;
   assign done      = done_r;
   assign vec_count = vec_count_r;
   assign w_data    = w_data_r;

endmodule

// File: tb/tb_vec_loader.sv
// Directed self-checking bench for vec_loader: collect, ack stall, flush, async reset, counter wrap.
module tb_vec_loader;

   localparam int W  = 16;
   localparam int NI = 8;
   localparam int CW = 8;

   logic                  clk;
   logic                  reset;
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [W-1:0]          in_data;
   logic                  wen;
   logic [NI:0][W-1:0]    w_data;
   logic                  wr_ack;
   logic                  busy;
   logic                  done;
   logic [CW-1:0]         vec_count;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   logic [CW-1:0] exp_cnt;
   logic [NI:0][W-1:0] exp_w;

   vec_loader #(.width(W), .num_inputs(NI), .cnt_width(CW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .wen(wen), .w_data(w_data), .wr_ack(wr_ack),
      .busy(busy), .done(done), .vec_count(vec_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One full vector: NI+1 beats from base, optional ack stall and flush while writing
   task automatic send_vec(input logic [W-1:0] base, input int stall, input bit flush_wr);
      for (int k = 0; k <= NI; k++) begin
         in_valid = 1'b1;
         in_data  = base + W'(k);
         exp_w[k] = base + W'(k);
         tick();
         if (k == NI - 1) begin
            chk("wen_low_collect", {159'd0, wen}, 160'd0);
            chk("busy_collect", {159'd0, busy}, 160'd1);
            chk("ready_collect", {159'd0, in_ready}, 160'd1);
         end
      end
      in_valid = 1'b0;
      flush    = flush_wr;
      chk("wen_rise", {159'd0, wen}, 160'd1);
      chk("ready_write", {159'd0, in_ready}, 160'd0);
      chk("busy_write", {159'd0, busy}, 160'd1);
      chk("wdata", {16'd0, w_data}, {16'd0, exp_w});
      tick();
      chk("wen_wait", {159'd0, wen}, 160'd1);
      chk("ready_wait", {159'd0, in_ready}, 160'd0);
      for (int s = 0; s < stall; s++) begin
         in_valid = 1'b1;
         in_data  = 16'hDEAD;
         tick();
         chk("stall_wen", {159'd0, wen}, 160'd1);
         chk("stall_ready", {159'd0, in_ready}, 160'd0);
         chk("stall_done", {159'd0, done}, 160'd0);
         chk("stall_wdata", {16'd0, w_data}, {16'd0, exp_w});
      end
      in_valid = 1'b0;
      wr_ack   = 1'b1;
      tick();
      wr_ack   = 1'b0;
      flush    = 1'b0;
      exp_cnt  = exp_cnt + 8'd1;
      chk("done_pulse", {159'd0, done}, 160'd1);
      chk("wen_fall", {159'd0, wen}, 160'd0);
      chk("ready_after_ack", {159'd0, in_ready}, 160'd1);
      chk("busy_after_ack", {159'd0, busy}, 160'd0);
      chk("vec_count", {152'd0, vec_count}, {152'd0, exp_cnt});
      tick();
      chk("done_end", {159'd0, done}, 160'd0);
   endtask

   initial begin
      int d0;
      reset    = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_data  = 16'h0000;
      wr_ack   = 1'b0;
      exp_cnt  = 8'd0;
      exp_w    = {((NI + 1) * W){1'b0}};
      tick();
      tick();
      reset = 1'b0;

      // reset state
      chk("rst_ready", {159'd0, in_ready}, 160'd1);
      chk("rst_wen", {159'd0, wen}, 160'd0);
      chk("rst_done", {159'd0, done}, 160'd0);
      chk("rst_busy", {159'd0, busy}, 160'd0);
      chk("rst_count", {152'd0, vec_count}, 160'd0);
      chk("rst_wdata", {16'd0, w_data}, 160'd0);

      // wr_ack outside WAIT_ACK is ignored
      wr_ack = 1'b1;
      tick();
      wr_ack = 1'b0;
      chk("stray_ack_done", {159'd0, done}, 160'd0);
      tick();
      chk("stray_ack_count", {152'd0, vec_count}, 160'd0);

      // first vector 0x0001..0x0009, immediate ack
      d0 = done_cnt;
      send_vec(16'h0001, 0, 1'b0);
      chk("slot0_first", {144'd0, w_data[0]}, 160'h0001);
      chk("slot8_first", {144'd0, w_data[NI]}, 160'h0009);
      chk("done_once_first", 160'(done_cnt - d0), 160'd1);

      // ack stall of 20 cycles with ignored beats
      d0 = done_cnt;
      send_vec(16'h0100, 20, 1'b0);
      chk("done_once_stall", 160'(done_cnt - d0), 160'd1);

      // flush after 5 beats, beat in the flush cycle is dropped
      d0 = done_cnt;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = 16'h0500 + 16'(k);
         tick();
      end
      chk("busy_partial", {159'd0, busy}, 160'd1);
      flush   = 1'b1;
      in_data = 16'hBEEF;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("busy_flushed", {159'd0, busy}, 160'd0);
      chk("flush_slot5", {144'd0, w_data[5]}, 160'h0105);
      chk("flush_slot0", {144'd0, w_data[0]}, 160'h0500);
      send_vec(16'h0A00, 0, 1'b0);
      chk("done_once_flush", 160'(done_cnt - d0), 160'd1);

      // flush held through WRITE and WAIT_ACK does not abort the write
      send_vec(16'h0B00, 3, 1'b1);
      chk("flush_wait_slot8", {144'd0, w_data[NI]}, 160'h0B08);

      // async reset in the middle of beat 4
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = 16'h0C00 + 16'(k);
         tick();
      end
      in_data = 16'h0C03;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_ready", {159'd0, in_ready}, 160'd1);
      chk("arst_wen", {159'd0, wen}, 160'd0);
      chk("arst_busy", {159'd0, busy}, 160'd0);
      chk("arst_done", {159'd0, done}, 160'd0);
      chk("arst_count", {152'd0, vec_count}, 160'd0);
      chk("arst_wdata", {16'd0, w_data}, 160'd0);
      in_valid = 1'b0;
      tick();
      tick();
      reset   = 1'b0;
      exp_cnt = 8'd0;
      send_vec(16'h0D00, 0, 1'b0);

      // counter wrap: 255 more vectors take vec_count from 1 through 255 to 0
      d0 = done_cnt;
      for (int v = 0; v < 255; v++) begin
         send_vec(16'(v * 16), 0, 1'b0);
      end
      chk("wrap_zero", {152'd0, vec_count}, 160'd0);
      chk("wrap_dones", 160'(done_cnt - d0), 160'd255);
      send_vec(16'h0E00, 1, 1'b0);
      chk("wrap_one", {152'd0, vec_count}, 160'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
